// File: rtl/iter_div_unit.sv
// Radix-2 restoring divider (quotient or remainder), one bit per cycle, WIDTH+1 cycle latency.
// Optional macro ITER_DIV_ZERO_FAST_EN short-cuts zero divisors straight to DONE.
module iter_div_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_signed,
    input  logic             op_mod,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             q_neg, r_neg, mod_q, zero_q;
    logic [TAG_W-1:0] tag_q;
    logic [WIDTH-1:0] res_q;

    logic             accept, div_zero, last;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   sh;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] rem_lo, q_fix, r_fix, fin;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = res_q;
    assign out_tag   = tag_q;

    assign accept   = in_valid & in_ready & ~flush;
    assign div_zero = (src2 == '0);
    assign last     = (cnt == CW'(WIDTH - 1));
    assign mag1     = (op_signed && src1[WIDTH-1]) ? -src1 : src1;
    assign mag2     = (op_signed && src2[WIDTH-1]) ? -src2 : src2;

    // Shift in the next dividend bit and try subtracting the divisor; the extra MSB of diff is the borrow.
    always_comb begin
        sh      = {rem[WIDTH-1:0], quo[WIDTH-1]};
        diff    = {1'b0, sh} - {2'b00, dvs};
        rem_nxt = diff[WIDTH+1] ? sh : diff[WIDTH:0];
        quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH+1]};
    end

    // A zero divisor naturally yields all-ones quotient and |src1| remainder; only the quotient sign fix must be skipped.
    always_comb begin
        rem_lo = rem_nxt[WIDTH-1:0];
        q_fix  = (q_neg && !zero_q) ? -quo_nxt : quo_nxt;
        r_fix  = r_neg ? -rem_lo : rem_lo;
        fin    = mod_q ? r_fix : q_fix;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef ITER_DIV_ZERO_FAST_EN
                    state_nxt = div_zero ? DONE : CALC;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC:    if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            mod_q  <= 1'b0;
            zero_q <= 1'b0;
            tag_q  <= '0;
            res_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt    <= '0;
                rem    <= '0;
                quo    <= mag1;
                dvs    <= mag2;
                q_neg  <= op_signed & (src1[WIDTH-1] ^ src2[WIDTH-1]);
                r_neg  <= op_signed & src1[WIDTH-1];
                mod_q  <= op_mod;
                zero_q <= div_zero;
                tag_q  <= in_tag;
`ifdef ITER_DIV_ZERO_FAST_EN
                if (div_zero) res_q <= op_mod ? src1 : '1;
`endif
            end else if (state == CALC && !flush) begin
                cnt <= cnt + 1'b1;
                rem <= rem_nxt;
                quo <= quo_nxt;
                if (last) res_q <= fin;
            end
        end
    end
endmodule

// File: tb/tb_iter_div_unit.sv
// Bench for iter_div_unit (WIDTH=32, TAG_W=5): vector table through a scoreboard plus flush/hold/reset sequences.
module tb_iter_div_unit;
    localparam int W = 32;
    localparam int T = 5;
`ifdef ITER_DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic         clk, reset, flush, in_valid, in_ready, op_signed, op_mod;
    logic [W-1:0] src1, src2, result;
    logic [T-1:0] in_tag, out_tag;
    logic         out_valid, out_ready, busy;

    iter_div_unit #(.WIDTH(W), .TAG_W(T)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op_signed(op_signed), .op_mod(op_mod), .src1(src1), .src2(src2), .in_tag(in_tag),
        .out_tag(out_tag), .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         sgn;
        logic         md;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [T-1:0] tag;
        logic [W-1:0] exp;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic [T-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic run_op(input vec_t v, input int exp_lat, input int hold);
        int   lat;
        exp_t e;
        lat = 0;
        while (!in_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid  = 1'b1;
        op_signed = v.sgn;
        op_mod    = v.md;
        src1      = v.a;
        src2      = v.b;
        in_tag    = v.tag;
        e.res     = v.exp;
        e.tag     = v.tag;
        sb.push_back(e);
        @(negedge clk);
        // Scramble the operand inputs after accept; the result must not depend on them.
        in_valid  = 1'b0;
        op_signed = 1'($urandom);
        op_mod    = 1'($urandom);
        src1      = $urandom;
        src2      = $urandom;
        in_tag    = T'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("result", 64'(result), 64'(e.res));
        chk("out_tag", 64'(out_tag), 64'(e.tag));
        chk("in_ready_done", 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_result", 64'(result), 64'(e.res));
            chk("hold_tag", 64'(out_tag), 64'(e.tag));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("idle_after_done", 64'(in_ready), 64'd1);
        chk("no_accept_on_leave", 64'(busy), 64'd0);
    endtask

    vec_t tbl[16];
    vec_t v;
    int   seen;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 32'd100,        32'd7,          5'h03, 32'd14};
        tbl[1]  = '{1'b0, 1'b1, 32'd100,        32'd7,          5'h03, 32'd2};
        tbl[2]  = '{1'b1, 1'b0, 32'hFFFFFFF9,   32'd2,          5'h01, 32'hFFFFFFFD};
        tbl[3]  = '{1'b1, 1'b1, 32'hFFFFFFF9,   32'd2,          5'h02, 32'hFFFFFFFF};
        tbl[4]  = '{1'b1, 1'b1, 32'd7,          32'hFFFFFFFE,   5'h04, 32'h00000001};
        tbl[5]  = '{1'b1, 1'b0, 32'd7,          32'hFFFFFFFE,   5'h05, 32'hFFFFFFFD};
        tbl[6]  = '{1'b1, 1'b0, 32'h80000000,   32'hFFFFFFFF,   5'h06, 32'h80000000};
        tbl[7]  = '{1'b1, 1'b1, 32'h80000000,   32'hFFFFFFFF,   5'h07, 32'h00000000};
        tbl[8]  = '{1'b0, 1'b0, 32'h12345678,   32'd0,          5'h08, 32'hFFFFFFFF};
        tbl[9]  = '{1'b0, 1'b1, 32'h12345678,   32'd0,          5'h09, 32'h12345678};
        tbl[10] = '{1'b1, 1'b0, 32'h12345678,   32'd0,          5'h0A, 32'hFFFFFFFF};
        tbl[11] = '{1'b1, 1'b1, 32'h12345678,   32'd0,          5'h0B, 32'h12345678};
        tbl[12] = '{1'b1, 1'b0, 32'hFFFFFF9C,   32'hFFFFFFF9,   5'h0C, 32'd14};
        tbl[13] = '{1'b1, 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   5'h0D, 32'hFFFFFFFE};
        tbl[14] = '{1'b0, 1'b1, 32'hFFFFFFFF,   32'd3,          5'h0E, 32'd0};
        tbl[15] = '{1'b0, 1'b0, 32'hFFFFFFF9,   32'd2,          5'h0F, 32'h7FFFFFFC};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; op_signed = 1'b0; op_mod = 1'b0;
        src1 = '0; src2 = '0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);

        for (int i = 0; i < 16; i++)
            run_op(tbl[i], (tbl[i].b == '0) ? ZLAT : 33, (i == 0) ? 5 : 0);

        // Flush on the 10th CALC cycle.
        @(negedge clk);
        in_valid = 1'b1; op_signed = 1'b0; op_mod = 1'b0; src1 = 32'd1000; src2 = 32'd3; in_tag = 5'h11;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_no_out_valid", 64'(seen), 64'd0);

        // Flush in IDLE blocks a simultaneous offer.
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_blocks_accept", 64'(busy), 64'd0);

        v = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h10, 5'h12, 32'h0FFFFFFF};
        run_op(v, 33, 0);

        // Reset mid-CALC beats flush and a pending offer.
        in_valid = 1'b1; op_signed = 1'b0; op_mod = 1'b0; src1 = 32'd55; src2 = 32'd5; in_tag = 5'h1F;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b1; flush = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_result", 64'(result), 64'd0);
        chk("mid_rst_out_tag", 64'(out_tag), 64'd0);

        run_op(tbl[0], 33, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/iter_div_unit.md
ITER_DIV_UNIT -- requirements
Module: iter_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width, legal range 2..64.
REQ-002 SHALL have parameter TAG_W, default 5, width of sideband tag carried with each operation.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  cancel in-flight operation (pipeline exception/ertn/refetch).
REQ-006 SHALL have port in_valid  input  1  operands offered.
REQ-007 SHALL have port in_ready  output  1  unit can accept; equals state==IDLE.
REQ-008 SHALL have port op_signed  input  1  1 = two's-complement, 0 = unsigned.
REQ-009 SHALL have port op_mod  input  1  1 = return remainder, 0 = return quotient.
REQ-010 SHALL have ports src1 (dividend), src2 (divisor)  input  WIDTH each.
REQ-011 SHALL have port in_tag  input  TAG_W, and out_tag  output  TAG_W  tag latched at accept.
REQ-012 SHALL have port out_valid  output  1  result available; equals state==DONE.
REQ-013 SHALL have port out_ready  input  1  consumer takes result.
REQ-014 SHALL have port result  output  WIDTH  quotient or remainder per latched op_mod.
REQ-015 SHALL have port busy  output  1  state!=IDLE.

Function
REQ-016 SHALL implement states IDLE, CALC, DONE; transitions IDLE->CALC on in_valid&in_ready&!flush, CALC->DONE when iteration counter reaches WIDTH, DONE->IDLE on out_ready.
REQ-017 SHALL latch op_signed, op_mod, in_tag, operand magnitudes and result signs in the accepting cycle; later input changes SHALL not affect the operation.
REQ-018 SHALL perform radix-2 restoring division, one quotient bit per CALC cycle, on unsigned magnitudes with a (WIDTH+1)-bit partial remainder.
REQ-019 SHALL raise out_valid exactly WIDTH+1 cycles after the accepting cycle (33 for WIDTH=32) for nonzero divisors.
REQ-020 SHALL negate the quotient when op_signed and sign(src1)!=sign(src2); SHALL give the remainder the sign of src1 when op_signed.
REQ-021 SHALL return, for signed most-negative / -1, quotient = most-negative value and remainder 0.
REQ-022 SHALL return, for src2==0 (either signedness), quotient all-ones and remainder = src1 unmodified.
REQ-023 SHALL hold result and out_tag stable while out_valid=1 and out_ready=0; in_ready SHALL stay 0 in DONE.
REQ-024 SHALL NOT accept a new operation in the cycle DONE is left; earliest next accept is the following IDLE cycle.
REQ-025 SHALL, on flush in any state, enter IDLE next cycle, discard the result, and not accept in_valid presented the same cycle; flush SHALL override out_ready and the CALC->DONE transition.
REQ-026 SHALL keep in_ready combinational only from state, not from in_valid or flush.

Reset
REQ-027 SHALL, when reset=1 at a rising edge, enter IDLE, clear counter; reset SHALL take priority over flush and handshakes, including mid-CALC.
REQ-028 SHALL present after reset: in_ready=1, out_valid=0, busy=0, result=0, out_tag=0.

Configuration
REQ-029 SHALL honour macro ITER_DIV_ZERO_FAST_EN: when defined, a zero divisor at accept SHALL go IDLE->DONE directly, out_valid 1 cycle after the accepting cycle.
REQ-030 SHALL, without ITER_DIV_ZERO_FAST_EN, run zero-divisor operations the full WIDTH+1 latency; result values per REQ-022 SHALL be identical in both builds.

Verification (WIDTH=32, TAG_W=5)
REQ-031 SHALL cover unsigned 100/7, op_mod=0 then 1, tag 5'h03 -> result 14 then 2, out_tag 5'h03, out_valid 33 cycles after accept.
REQ-032 SHALL cover signed -7/2 -> quotient 0xFFFFFFFD; op_mod=1 -> remainder 0xFFFFFFFF; signed 7/-2 remainder -> 0x00000001.
REQ-033 SHALL cover signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0x00000000.
REQ-034 SHALL cover src1=0x12345678, src2=0, both signedness -> quotient 0xFFFFFFFF, remainder 0x12345678; latency 1 with macro, 33 without.
REQ-035 SHALL cover flush on 10th CALC cycle -> out_valid never rises, in_ready=1 next cycle; next op 0xFFFFFFFF/0x10 unsigned -> 0x0FFFFFFF.
REQ-036 SHALL cover out_ready held 0 for 5 cycles in DONE -> result/out_tag constant, in_ready=0; out_ready=1 -> IDLE next cycle; reset asserted mid-CALC -> REQ-028 values next cycle.
